ring_router_mux: RTL and testbench
==================================

# ring_router_mux

Merges two flit streams into the outgoing ring link of a debug ring router: pass-through traffic (non-local flits from the router's demux stage) and flits injected by the local debug module. Arbitration is per packet (worm), so flits of different packets never interleave. The merged stream leaves through a one-entry output register toward the next router, so the ring path is cut combinationally at every hop.

## Interface
- Parameters: none. Flit format is the codebase `dii_flit`: `data[15:0]`, `last`, `valid`.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_ring`  in  dii_flit  pass-through flits from the demux `out_ring`.
- `in_ring_ready`  out  1  accept for `in_ring`.
- `in_local`  in  dii_flit  flits injected by the local module.
- `in_local_ready`  out  1  accept for `in_local`.
- `out_ring`  out  dii_flit  registered output to the next router.
- `out_ring_ready`  in  1  downstream accept.

## Operation
- Transfer on any port: `valid & ready` at a rising edge.
- Output register `obuf` (data, last, valid). `slot = !obuf.valid | out_ring_ready`.
- Arbiter FSM states:
  - IDLE: no packet in flight.
  - WORM_RING: a ring packet is in flight.
  - WORM_LOCAL: a local packet is in flight.
- IDLE grant, combinational:
  - Only one input valid: grant that input.
  - Both valid: grant the input not named by `last_grant`.
  - Neither valid: no grant.
- WORM_x: grant x only. The other input's ready is 0.
- Ready rules:
  - `in_x_ready = grant_x & slot & !rst`.
  - The non-granted input's ready is 0.
  - Ready never depends on the non-granted input's valid.
- On an accepted flit:
  - Flit loads into `obuf`.
  - In IDLE: `last_grant <= x`. If `last=0`, go to WORM_x. If `last=1` (single-flit packet), stay in IDLE.
  - In WORM_x with `last=1`: return to IDLE.
- `obuf` with no accept:
  - `out_ring_ready=1`: `obuf.valid <= 0`.
  - `out_ring_ready=0`: `obuf` holds. Data and last stay stable while valid and not accepted.
- Reset values:
  - `out_ring.valid=0`, `out_ring.data=0`, `out_ring.last=0`.
  - `in_ring_ready=0`, `in_local_ready=0`.
  - FSM in IDLE.
  - `last_grant=LOCAL`, so the ring input wins the first tie.
- Reset mid-packet: FSM goes to IDLE and `obuf` is discarded. Partial worms are dropped. Upstream stages are reset by the same `rst`.
- Packet content is not inspected; only `last` matters. `data` passes through bit-exact.

## Timing
- Latency: an input accepted at edge N appears on `out_ring` after edge N, i.e. 1 cycle.
- Throughput: 1 flit/cycle sustained while `out_ring_ready=1`.
- Backpressure is combinational: `out_ring_ready` reaches both input readies in the same cycle, with no extra buffering.
- Grant switch: after a `last` flit is accepted, the other input can be accepted on the very next edge. There are no bubble cycles.
- Simultaneous events:
  - A new first flit arriving while WORM_x accepts its `last` is arbitrated in the following cycle (IDLE).
  - `obuf` drain and load in the same cycle are legal and required.

## Configuration
- `RING_ROUTER_MUX_RING_PRIO_EN`
  - Defined: strict priority for `in_ring`. In IDLE the ring input wins whenever it is valid; `last_grant` is unused. Local injection can be starved, but forwarded traffic never stalls behind local traffic.
  - Undefined (default): round-robin as described above. Neither input can be starved.
- Worm atomicity holds in both modes.

## Test plan
- Single-flit pass-through: `in_ring` {data=16'h0005, last=1}, `out_ring_ready=1` -> `out_ring` shows 16'h0005, last=1, one cycle later; `in_local_ready=0` during that cycle only if `in_local` is not granted.
- Worm atomicity: ring 4-flit packet A0..A3 and local 2-flit packet B0..B1, both valid from the same cycle -> output A0,A1,A2,A3,B0,B1 with no interleaving; `in_local_ready=0` during A1..A3.
- Round-robin: both inputs continuously offer single-flit packets -> output alternates ring, local, ring, local, …; ring first after reset. With `RING_ROUTER_MUX_RING_PRIO_EN` defined -> ring only; local ready stays 0.
- Backpressure: hold `out_ring_ready=0` for 3 cycles mid-worm -> `out_ring` data/last/valid stable; both input readies 0; no flit lost or duplicated after release.
- Full rate: 8-flit local packet with `out_ring_ready=1` -> 8 consecutive output cycles, no bubbles; the next ring packet follows immediately.
- Reset mid-worm: assert `rst` after flit 2 of a 5-flit packet -> next cycle `out_ring.valid=0`, readies 0, FSM IDLE; a new packet after reset is forwarded correctly.

Source files
------------

// File: rtl/ring_router_mux.sv
// ============================================================================
// Module   : ring_router_mux
// Brief    : Merges pass-through ring flits and locally injected flits onto
//            the outgoing ring link. Arbitration is per packet (worm), and the
//            merged stream leaves through a one-entry output register.
// Config   : RING_ROUTER_MUX_RING_PRIO_EN - when defined, the ring input has
//            strict priority in IDLE; otherwise round-robin between packets.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ring_router_mux (
    input  logic        clk,
    input  logic        rst,

    input  logic [15:0] in_ring_data,
    input  logic        in_ring_last,
    input  logic        in_ring_valid,
    output logic        in_ring_ready,

    input  logic [15:0] in_local_data,
    input  logic        in_local_last,
    input  logic        in_local_valid,
    output logic        in_local_ready,

    output logic [15:0] out_ring_data,
    output logic        out_ring_last,
    output logic        out_ring_valid,
    input  logic        out_ring_ready
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WORM_RING  = 2'd1,
        ST_WORM_LOCAL = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [15:0] obuf_data_q;
    logic        obuf_last_q;
    logic        obuf_valid_q;

`ifndef RING_ROUTER_MUX_RING_PRIO_EN
    // 1 = local input won the last IDLE arbitration, 0 = ring input did
    logic        last_grant_q;
`endif

    logic        w_slot;
    logic        w_grant_ring;
    logic        w_grant_local;
    logic        w_acc_ring;
    logic        w_acc_local;

    // Output register can take a flit when empty or when it drains this cycle
    assign w_slot = ~obuf_valid_q | out_ring_ready;

    // Grant selection: arbitrate in IDLE, lock onto the owning input mid-worm
    always_comb begin
        w_grant_ring  = 1'b0;
        w_grant_local = 1'b0;
        case (state_q)
            ST_IDLE: begin
`ifdef RING_ROUTER_MUX_RING_PRIO_EN
                w_grant_ring  = in_ring_valid;
                w_grant_local = in_local_valid & ~in_ring_valid;
`else
                if (in_ring_valid & in_local_valid) begin
                    w_grant_ring  = last_grant_q;
                    w_grant_local = ~last_grant_q;
                end else begin
                    w_grant_ring  = in_ring_valid;
                    w_grant_local = in_local_valid;
                end
`endif
            end
            ST_WORM_RING:  w_grant_ring  = 1'b1;
            ST_WORM_LOCAL: w_grant_local = 1'b1;
            default: begin
                w_grant_ring  = 1'b0;
                w_grant_local = 1'b0;
            end
        endcase
    end

    // Backpressure reaches the granted input combinationally; reset blocks all accepts
    assign in_ring_ready  = w_grant_ring  & w_slot & ~rst;
    assign in_local_ready = w_grant_local & w_slot & ~rst;

    assign w_acc_ring  = in_ring_valid  & in_ring_ready;
    assign w_acc_local = in_local_valid & in_local_ready;

    // Next-state: open a worm on a non-last first flit, close it on its last flit
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_acc_ring & ~in_ring_last) begin
                    state_d = ST_WORM_RING;
                end else if (w_acc_local & ~in_local_last) begin
                    state_d = ST_WORM_LOCAL;
                end
            end
            ST_WORM_RING: begin
                if (w_acc_ring & in_ring_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WORM_LOCAL: begin
                if (w_acc_local & in_local_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Arbiter state register; reset drops any partial worm
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifndef RING_ROUTER_MUX_RING_PRIO_EN
    // Remember which input started the most recent packet for round-robin fairness
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else if (state_q == ST_IDLE) begin
            if (w_acc_ring) begin
                last_grant_q <= 1'b0;
            end else if (w_acc_local) begin
                last_grant_q <= 1'b1;
            end
        end
    end
`endif

    // Output register: load on accept, clear when drained, hold under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            obuf_data_q  <= 16'h0000;
            obuf_last_q  <= 1'b0;
            obuf_valid_q <= 1'b0;
        end else if (w_acc_ring) begin
            obuf_data_q  <= in_ring_data;
            obuf_last_q  <= in_ring_last;
            obuf_valid_q <= 1'b1;
        end else if (w_acc_local) begin
            obuf_data_q  <= in_local_data;
            obuf_last_q  <= in_local_last;
            obuf_valid_q <= 1'b1;
        end else if (out_ring_ready) begin
            obuf_valid_q <= 1'b0;
        end
    end

    assign out_ring_data  = obuf_data_q;
    assign out_ring_last  = obuf_last_q;
    assign out_ring_valid = obuf_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_ring_router_mux.sv
// ============================================================================
// Module   : tb_ring_router_mux
// Brief    : Self-checking bench for ring_router_mux. A packet-level reference
//            model predicts readies and the output register each cycle; the
//            transferred output stream is also checked for order and worm
//            atomicity. Honours RING_ROUTER_MUX_RING_PRIO_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ring_router_mux;

    localparam int NONE  = 0;
    localparam int RING  = 1;
    localparam int LOCAL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_ring_data = '0;
    logic        in_ring_last = 1'b0;
    logic        in_ring_valid = 1'b0;
    logic        in_ring_ready;
    logic [15:0] in_local_data = '0;
    logic        in_local_last = 1'b0;
    logic        in_local_valid = 1'b0;
    logic        in_local_ready;
    logic [15:0] out_ring_data;
    logic        out_ring_last;
    logic        out_ring_valid;
    logic        out_ring_ready = 1'b0;

    always #5 clk = ~clk;

    ring_router_mux dut (
        .clk            (clk),
        .rst            (rst),
        .in_ring_data   (in_ring_data),
        .in_ring_last   (in_ring_last),
        .in_ring_valid  (in_ring_valid),
        .in_ring_ready  (in_ring_ready),
        .in_local_data  (in_local_data),
        .in_local_last  (in_local_last),
        .in_local_valid (in_local_valid),
        .in_local_ready (in_local_ready),
        .out_ring_data  (out_ring_data),
        .out_ring_last  (out_ring_last),
        .out_ring_valid (out_ring_valid),
        .out_ring_ready (out_ring_ready)
    );

    typedef struct {
        logic [15:0] d;
        logic        l;
    } flit_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Pending flits per input, and the log of flits that left on out_ring
    flit_t       rq[$];
    flit_t       lq[$];
    logic [15:0] log_d[$];
    logic        log_l[$];
    int          log_c[$];

    // Reference model state: packet owner, last winner, output register content
    int          m_owner;
    int          m_lastg;
    bit          m_ov;
    logic [15:0] m_od;
    logic        m_ol;

    int rvpct, lvpct, orpct;
    bit orpat[$];

    task automatic model_reset();
        m_owner = NONE;
        m_lastg = LOCAL;
        m_ov    = 1'b0;
        m_od    = 16'h0000;
        m_ol    = 1'b0;
    endtask

    task automatic push_pkt(input int src, input logic [15:0] base, input int len);
        flit_t f;
        for (int i = 0; i < len; i++) begin
            f.d = base + 16'(i);
            f.l = (i == len - 1);
            if (src == RING) rq.push_back(f);
            else             lq.push_back(f);
        end
    endtask

    // One clock of stimulus + model prediction + comparison
    task automatic step();
        bit    rv, lv, orr, slot, exp_rr, exp_lr, acc_r, acc_l;
        int    g;
        flit_t rf, lf, f;
        rv = (rq.size() > 0) && ($urandom_range(99) < rvpct);
        lv = (lq.size() > 0) && ($urandom_range(99) < lvpct);
        if (orpat.size() > 0) orr = orpat.pop_front();
        else                  orr = ($urandom_range(99) < orpct);
        rf.d = 16'($urandom); rf.l = 1'($urandom);
        lf.d = 16'($urandom); lf.l = 1'($urandom);
        if (rv) rf = rq[0];
        if (lv) lf = lq[0];
        in_ring_valid  = rv;  in_ring_data  = rf.d; in_ring_last  = rf.l;
        in_local_valid = lv;  in_local_data = lf.d; in_local_last = lf.l;
        out_ring_ready = orr;
        #1;
        slot = !m_ov || orr;
        g = m_owner;
        if (g == NONE) begin
`ifdef RING_ROUTER_MUX_RING_PRIO_EN
            if (rv)      g = RING;
            else if (lv) g = LOCAL;
`else
            if (rv && lv) g = (m_lastg == LOCAL) ? RING : LOCAL;
            else if (rv)  g = RING;
            else if (lv)  g = LOCAL;
`endif
        end
        exp_rr = (g == RING)  && slot;
        exp_lr = (g == LOCAL) && slot;
        n_checks++;
        if (in_ring_ready !== exp_rr) begin
            n_fail++;
            $display("FAIL in_ring_ready cyc=%0d got=%b exp=%b", cyc, in_ring_ready, exp_rr);
        end
        n_checks++;
        if (in_local_ready !== exp_lr) begin
            n_fail++;
            $display("FAIL in_local_ready cyc=%0d got=%b exp=%b", cyc, in_local_ready, exp_lr);
        end
        n_checks++;
        if (out_ring_valid !== m_ov) begin
            n_fail++;
            $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_ring_valid, m_ov);
        end
        if (m_ov) begin
            n_checks++;
            if (out_ring_data !== m_od || out_ring_last !== m_ol) begin
                n_fail++;
                $display("FAIL out_flit cyc=%0d got=%h/%b exp=%h/%b",
                         cyc, out_ring_data, out_ring_last, m_od, m_ol);
            end
        end
        if (out_ring_valid === 1'b1 && orr) begin
            log_d.push_back(out_ring_data);
            log_l.push_back(out_ring_last);
            log_c.push_back(cyc);
        end
        @(posedge clk);
        acc_r = (g == RING)  && rv && slot;
        acc_l = (g == LOCAL) && lv && slot;
        if (acc_r || acc_l) begin
            if (acc_r) begin f = rf; void'(rq.pop_front()); end
            else       begin f = lf; void'(lq.pop_front()); end
            if (m_owner == NONE) begin
                m_lastg = g;
                if (!f.l) m_owner = g;
            end else if (f.l) begin
                m_owner = NONE;
            end
            m_ov = 1'b1;
            m_od = f.d;
            m_ol = f.l;
        end else if (orr) begin
            m_ov = 1'b0;
        end
        cyc++;
        #1;
    endtask

    task automatic run(input int maxc);
        int n = 0;
        while ((rq.size() > 0 || lq.size() > 0 || m_ov) && n < maxc) begin
            step();
            n++;
        end
        n_checks++;
        if (rq.size() > 0 || lq.size() > 0 || m_ov) begin
            n_fail++;
            $display("FAIL drain_timeout got ring_left=%0d local_left=%0d obuf=%b exp all empty",
                     rq.size(), lq.size(), m_ov);
        end
        in_ring_valid  = 1'b0;
        in_local_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_ring_valid  = 1'b1; in_ring_data  = 16'($urandom); in_ring_last  = 1'b0;
        in_local_valid = 1'b1; in_local_data = 16'($urandom); in_local_last = 1'b0;
        out_ring_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ring_ready !== 1'b0 || in_local_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_readies got=%b%b exp=00", in_ring_ready, in_local_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_ring_valid !== 1'b0 || out_ring_data !== 16'h0000 || out_ring_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out got=%b/%h/%b exp=0/0000/0",
                     out_ring_valid, out_ring_data, out_ring_last);
        end
        rst = 1'b0;
        in_ring_valid  = 1'b0;
        in_local_valid = 1'b0;
        model_reset();
        rq.delete(); lq.delete(); orpat.delete();
        log_d.delete(); log_l.delete(); log_c.delete();
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_single();
        flit_t f;
        int    c0;
        f.d = 16'h0005; f.l = 1'b1;
        rq.push_back(f);
        rvpct = 100; lvpct = 0; orpct = 100;
        c0 = cyc;
        step();
        n_checks++;
        if (out_ring_valid !== 1'b1 || out_ring_data !== 16'h0005 || out_ring_last !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency got=%b/%h/%b exp=1/0005/1",
                     out_ring_valid, out_ring_data, out_ring_last);
        end
        run(20);
        n_checks++;
        if (log_d.size() != 1 || log_d[0] !== 16'h0005 || log_c[0] != c0 + 1) begin
            n_fail++;
            $display("FAIL single_log got size=%0d exp size=1 data=0005 at cyc %0d",
                     log_d.size(), c0 + 1);
        end
    endtask

    task automatic test_worm();
        logic [15:0] exp_d[$];
        do_reset();
        push_pkt(RING, 16'hA000, 4);
        push_pkt(LOCAL, 16'hB000, 2);
        exp_d = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hB000, 16'hB001};
        rvpct = 100; lvpct = 100; orpct = 100;
        run(50);
        n_checks++;
        if (log_d.size() != exp_d.size()) begin
            n_fail++;
            $display("FAIL worm_count got=%0d exp=%0d", log_d.size(), exp_d.size());
        end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                n_checks++;
                if (log_d[i] !== exp_d[i]) begin
                    n_fail++;
                    $display("FAIL worm_order idx=%0d got=%h exp=%h", i, log_d[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_d[$];
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_pkt(RING,  16'hA100 + 16'(i), 1);
            push_pkt(LOCAL, 16'hB100 + 16'(i), 1);
        end
`ifdef RING_ROUTER_MUX_RING_PRIO_EN
        for (int i = 0; i < 6; i++) exp_d.push_back(16'hA100 + 16'(i));
        for (int i = 0; i < 6; i++) exp_d.push_back(16'hB100 + 16'(i));
`else
        for (int i = 0; i < 6; i++) begin
            exp_d.push_back(16'hA100 + 16'(i));
            exp_d.push_back(16'hB100 + 16'(i));
        end
`endif
        rvpct = 100; lvpct = 100; orpct = 100;
        run(60);
        n_checks++;
        if (log_d.size() != exp_d.size()) begin
            n_fail++;
            $display("FAIL rr_count got=%0d exp=%0d", log_d.size(), exp_d.size());
        end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                n_checks++;
                if (log_d[i] !== exp_d[i]) begin
                    n_fail++;
                    $display("FAIL rr_order idx=%0d got=%h exp=%h", i, log_d[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_d[$];
        do_reset();
        push_pkt(RING, 16'hA200, 4);
        push_pkt(LOCAL, 16'hB200, 1);
        exp_d = '{16'hA200, 16'hA201, 16'hA202, 16'hA203, 16'hB200};
        orpat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        rvpct = 100; lvpct = 100; orpct = 100;
        run(50);
        n_checks++;
        if (log_d.size() != exp_d.size()) begin
            n_fail++;
            $display("FAIL bp_count got=%0d exp=%0d", log_d.size(), exp_d.size());
        end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                n_checks++;
                if (log_d[i] !== exp_d[i]) begin
                    n_fail++;
                    $display("FAIL bp_order idx=%0d got=%h exp=%h", i, log_d[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_full_rate();
        do_reset();
        push_pkt(LOCAL, 16'hB300, 8);
        push_pkt(RING,  16'hA300, 3);
        rvpct = 0; lvpct = 100; orpct = 100;
        step();
        step();
        rvpct = 100;
        run(50);
        n_checks++;
        if (log_d.size() != 11) begin
            n_fail++;
            $display("FAIL full_rate_count got=%0d exp=11", log_d.size());
        end else begin
            for (int i = 0; i < 11; i++) begin
                n_checks++;
                if (log_d[i] !== ((i < 8) ? 16'hB300 + 16'(i) : 16'hA300 + 16'(i - 8)) ||
                    (i > 0 && log_c[i] != log_c[i-1] + 1)) begin
                    n_fail++;
                    $display("FAIL full_rate idx=%0d got=%h@%0d exp=%h back-to-back", i, log_d[i],
                             log_c[i], (i < 8) ? 16'hB300 + 16'(i) : 16'hA300 + 16'(i - 8));
                end
            end
        end
    endtask

    task automatic test_reset_mid_worm();
        do_reset();
        push_pkt(RING, 16'hA400, 5);
        rvpct = 100; lvpct = 0; orpct = 100;
        step();
        step();
        do_reset();
        push_pkt(LOCAL, 16'hB400, 2);
        rvpct = 0; lvpct = 100; orpct = 100;
        run(30);
        n_checks++;
        if (log_d.size() != 2 || log_d[0] !== 16'hB400 || log_d[1] !== 16'hB401) begin
            n_fail++;
            $display("FAIL reset_mid_worm got size=%0d exp B400,B401", log_d.size());
        end
    endtask

    task automatic test_random();
        flit_t er[$];
        flit_t el[$];
        flit_t f;
        int    cur, s, len;
        for (int it = 0; it < 3; it++) begin
            do_reset();
            er.delete(); el.delete();
            for (int p = 0; p < 40; p++) begin
                s   = ($urandom_range(1) == 0) ? RING : LOCAL;
                len = $urandom_range(5, 1);
                for (int i = 0; i < len; i++) begin
                    f.d = {(s == LOCAL), 15'($urandom)};
                    f.l = (i == len - 1);
                    if (s == RING) begin rq.push_back(f); er.push_back(f); end
                    else           begin lq.push_back(f); el.push_back(f); end
                end
            end
            rvpct = 40 + 20 * it; lvpct = 90 - 20 * it; orpct = 50 + 25 * it;
            run(4000);
            cur = NONE;
            for (int i = 0; i < log_d.size(); i++) begin
                s = log_d[i][15] ? LOCAL : RING;
                n_checks++;
                if (cur != NONE && s != cur) begin
                    n_fail++;
                    $display("FAIL rand_interleave idx=%0d got src=%0d exp src=%0d", i, s, cur);
                end
                if (s == RING && er.size() > 0) f = er.pop_front();
                else if (s == LOCAL && el.size() > 0) f = el.pop_front();
                else begin f.d = 16'hxxxx; f.l = 1'bx; end
                n_checks++;
                if (log_d[i] !== f.d || log_l[i] !== f.l) begin
                    n_fail++;
                    $display("FAIL rand_flit idx=%0d got=%h/%b exp=%h/%b",
                             i, log_d[i], log_l[i], f.d, f.l);
                end
                cur = log_l[i] ? NONE : s;
            end
            n_checks++;
            if (er.size() != 0 || el.size() != 0) begin
                n_fail++;
                $display("FAIL rand_lost got ring_missing=%0d local_missing=%0d exp 0",
                         er.size(), el.size());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_worm();
        test_round_robin();
        test_backpressure();
        test_full_rate();
        test_reset_mid_worm();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
